// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;
  localparam int PC_WIDTH    = 32;
  localparam int INSTR_WIDTH = 32;

  typedef enum logic {
    S_REQ   = 1'b0,
    S_DRAIN = 1'b1
  } fetch_state_t;

  localparam logic [INSTR_WIDTH-1:0] IFID_BUBBLE_INSTR = 32'h0;
endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {pc, instr, valid} holder; clear beats load, load beats pop.
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   load,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [PC_WIDTH-1:0]    load_pc,
  input  logic [INSTR_WIDTH-1:0] load_instr,
  output logic                   skid_valid,
  output logic [PC_WIDTH-1:0]    skid_pc,
  output logic [INSTR_WIDTH-1:0] skid_instr
);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= IFID_BUBBLE_INSTR;
    end else if (clear) begin
      skid_valid <= 1'b0;
    end else if (load) begin
      skid_valid <= 1'b1;
      skid_pc    <= load_pc;
      skid_instr <= load_instr;
    end else if (pop) begin
      skid_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register and one-entry skid buffer.
// Define FETCH_PERF_EN to add the perf_fetched / perf_stall_cycles counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [PC_WIDTH-1:0] PC_STEP  = 32'd4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   stall_in,
  input  logic                   branch_taken_in,
  input  logic [PC_WIDTH-1:0]    branch_target_in,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ready,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
`ifdef FETCH_PERF_EN
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_stall_cycles,
`endif
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic                   valid_out
);

  fetch_state_t            state_reg;
  logic [PC_WIDTH-1:0]     pc_reg;
  logic [PC_WIDTH-1:0]     redirect_reg;
  logic                    skid_valid;
  logic [PC_WIDTH-1:0]     skid_pc;
  logic [INSTR_WIDTH-1:0]  skid_instr;
  logic                    accept;
  logic                    adv;
  logic                    fetch_ok;
  logic                    skid_load;
  logic                    skid_pop;

  assign imem_addr = pc_reg;
  assign imem_req  = (state_reg == S_REQ && !skid_valid) || state_reg == S_DRAIN;
  assign accept    = imem_req && imem_ready;
  assign adv       = !valid_out || !stall_in;
  // A fetch is kept only in S_REQ and only when no redirect flushes it.
  assign fetch_ok  = accept && state_reg == S_REQ && !branch_taken_in;
  assign skid_load = fetch_ok && !adv;
  assign skid_pop  = adv && skid_valid;

  fetch_skid_buffer u_skid (
    .CLK        (CLK),
    .RESET      (RESET),
    .load       (skid_load),
    .pop        (skid_pop),
    .clear      (branch_taken_in),
    .load_pc    (pc_reg),
    .load_instr (imem_rdata),
    .skid_valid (skid_valid),
    .skid_pc    (skid_pc),
    .skid_instr (skid_instr)
  );

  // PC / request state machine
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg    <= S_REQ;
      pc_reg       <= RESET_PC;
      redirect_reg <= '0;
    end else begin
      case (state_reg)
        S_REQ: begin
          if (branch_taken_in) begin
            if (imem_req && !imem_ready) begin
              redirect_reg <= branch_target_in;
              state_reg    <= S_DRAIN;
            end else begin
              pc_reg <= branch_target_in;
            end
          end else if (accept) begin
            pc_reg <= pc_reg + PC_STEP;
          end
        end
        S_DRAIN: begin
          if (accept) begin
            pc_reg    <= branch_taken_in ? branch_target_in : redirect_reg;
            state_reg <= S_REQ;
          end else if (branch_taken_in) begin
            redirect_reg <= branch_target_in;
          end
        end
        default: state_reg <= S_REQ;
      endcase
    end
  end

  // IF/ID pipeline register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_out    <= '0;
      instr_out <= IFID_BUBBLE_INSTR;
      valid_out <= 1'b0;
    end else if (branch_taken_in) begin
      valid_out <= 1'b0;
    end else if (adv) begin
      if (skid_valid) begin
        pc_out    <= skid_pc;
        instr_out <= skid_instr;
        valid_out <= 1'b1;
      end else if (fetch_ok) begin
        pc_out    <= pc_reg;
        instr_out <= imem_rdata;
        valid_out <= 1'b1;
      end else begin
        valid_out <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      perf_fetched      <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (fetch_ok)
        perf_fetched <= perf_fetched + 32'd1;
      if (valid_out && stall_in)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; memory returns {16'hC0DE, addr[15:0]}.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        stall_in = 1'b0;
  logic        branch_taken_in = 1'b0;
  logic [31:0] branch_target_in = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        valid_out;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall_cycles;
`endif

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

  fetch_stage dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .stall_in         (stall_in),
    .branch_taken_in  (branch_taken_in),
    .branch_target_in (branch_target_in),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rdata       (imem_rdata),
`ifdef FETCH_PERF_EN
    .perf_fetched     (perf_fetched),
    .perf_stall_cycles(perf_stall_cycles),
`endif
    .pc_out           (pc_out),
    .instr_out        (instr_out),
    .valid_out        (valid_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("check %-14s observed=%h expected=%h ok", tag, obs, exp);
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle: inputs were set at a negedge, sample at the next negedge.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    @(negedge CLK);
    chk("rst_valid", {31'b0, valid_out}, 32'h0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h1);
    RESET = 1'b0;

    // Streaming fetch at one instruction per cycle
    tick();
    chk("s0_valid", {31'b0, valid_out}, 32'h1);
    chk("s0_pc", pc_out, 32'h0);
    chk("s0_instr", instr_out, 32'hC0DE_0000);
    chk("s0_addr", imem_addr, 32'h4);
    tick();
    chk("s1_pc", pc_out, 32'h4);
    chk("s1_instr", instr_out, 32'hC0DE_0004);
    chk("s1_addr", imem_addr, 32'h8);

    // Stall three cycles: pc 8 goes to the skid, request drops
    stall_in = 1'b1;
    tick();
    chk("st0_pc", pc_out, 32'h4);
    chk("st0_valid", {31'b0, valid_out}, 32'h1);
    chk("st0_req", {31'b0, imem_req}, 32'h0);
    chk("st0_addr", imem_addr, 32'hC);
    tick();
    chk("st1_pc", pc_out, 32'h4);
    chk("st1_req", {31'b0, imem_req}, 32'h0);
    tick();
    chk("st2_pc", pc_out, 32'h4);
    stall_in = 1'b0;
    tick();
    chk("sk_pc", pc_out, 32'h8);
    chk("sk_instr", instr_out, 32'hC0DE_0008);
    chk("sk_req", {31'b0, imem_req}, 32'h1);
    chk("sk_addr", imem_addr, 32'hC);
    tick();
    chk("post_pc", pc_out, 32'hC);
    chk("post_addr", imem_addr, 32'h10);

    // Memory not ready for two cycles
    imem_ready = 1'b0;
    tick();
    chk("nr0_valid", {31'b0, valid_out}, 32'h0);
    chk("nr0_addr", imem_addr, 32'h10);
    tick();
    chk("nr1_valid", {31'b0, valid_out}, 32'h0);
    chk("nr1_addr", imem_addr, 32'h10);
    imem_ready = 1'b1;
    tick();
    chk("nr_pc", pc_out, 32'h10);
    chk("nr_instr", instr_out, 32'hC0DE_0010);
    chk("nr_addr", imem_addr, 32'h14);

    // Redirect while a request is outstanding -> drain
    imem_ready = 1'b0;
    tick();
    branch_taken_in = 1'b1;
    branch_target_in = 32'h100;
    tick();
    branch_taken_in = 1'b0;
    chk("dr0_valid", {31'b0, valid_out}, 32'h0);
    chk("dr0_addr", imem_addr, 32'h14);
    chk("dr0_req", {31'b0, imem_req}, 32'h1);
    tick();
    chk("dr1_addr", imem_addr, 32'h14);
    imem_ready = 1'b1;
    tick();
    chk("dr2_valid", {31'b0, valid_out}, 32'h0);
    chk("dr2_addr", imem_addr, 32'h100);
    tick();
    chk("br_valid", {31'b0, valid_out}, 32'h1);
    chk("br_pc", pc_out, 32'h100);
    chk("br_instr", instr_out, 32'hC0DE_0100);
    chk("br_addr", imem_addr, 32'h104);

    // Redirect together with stall and a full skid
    stall_in = 1'b1;
    tick();
    chk("bs0_req", {31'b0, imem_req}, 32'h0);
    chk("bs0_pc", pc_out, 32'h100);
    branch_taken_in = 1'b1;
    branch_target_in = 32'h200;
    tick();
    branch_taken_in = 1'b0;
    chk("bs1_valid", {31'b0, valid_out}, 32'h0);
    chk("bs1_req", {31'b0, imem_req}, 32'h1);
    chk("bs1_addr", imem_addr, 32'h200);
    tick();
    chk("bs2_pc", pc_out, 32'h200);
    chk("bs2_valid", {31'b0, valid_out}, 32'h1);
    chk("bs2_addr", imem_addr, 32'h204);
    stall_in = 1'b0;
    tick();
    chk("bs3_pc", pc_out, 32'h204);

    // Redirect coinciding with an accept: data discarded
    branch_taken_in = 1'b1;
    branch_target_in = 32'h40;
    tick();
    branch_taken_in = 1'b0;
    chk("ba_valid", {31'b0, valid_out}, 32'h0);
    chk("ba_addr", imem_addr, 32'h40);
    tick();
    chk("ba_pc", pc_out, 32'h40);

    // Reset mid-request
    imem_ready = 1'b0;
    stall_in = 1'b1;
    tick();
    chk("mr_req", {31'b0, imem_req}, 32'h1);
    chk("mr_valid", {31'b0, valid_out}, 32'h1);
    #2 RESET = 1'b1;
    #1;
    chk("ar_valid", {31'b0, valid_out}, 32'h0);
    chk("ar_pc", pc_out, 32'h0);
    chk("ar_instr", instr_out, 32'h0);
    chk("ar_addr", imem_addr, 32'h0);
    @(negedge CLK);
    RESET = 1'b0;
    stall_in = 1'b0;
    imem_ready = 1'b1;
    tick();
    chk("rr_pc", pc_out, 32'h0);
    chk("rr_valid", {31'b0, valid_out}, 32'h1);
    chk("rr_addr", imem_addr, 32'h4);

    // PC wraps at 2^32
    branch_taken_in = 1'b1;
    branch_target_in = 32'hFFFF_FFFC;
    tick();
    branch_taken_in = 1'b0;
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wr_pc", pc_out, 32'hFFFF_FFFC);
    chk("wr_instr", instr_out, 32'hC0DE_FFFC);
    chk("wr_addr2", imem_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
